video_vram_arbiter: RTL

Shares one single-port synchronous video RAM (tile/texture store) between the CPU iomem bus and the display fetch engine. Display fetches have priority; a starvation guard bounds CPU wait. Sits between the picosoc iomem decode, the video fetch pipeline and the BRAM macro.

---
 rtl/video_vram_arbiter_if.sv | 33 +++
 rtl/video_vram_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/video_vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter (slave) and its CPU, display fetch and RAM neighbours (master).
interface video_vram_arbiter_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              cpu_valid;
    logic              cpu_ready;
    logic [3:0]        cpu_wstrb;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic              vid_rvalid;
    logic [31:0]       vid_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  cpu_valid, cpu_wstrb, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
        output cpu_ready, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_valid, cpu_wstrb, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
        input  cpu_ready, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/video_vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has priority, CPU is forced a slot after CPU_MAX_WAIT losses.
// Optional macro VIDEO_ARB_STATS_EN adds the stall_cnt output counting CPU cycles lost to video.
module video_vram_arbiter #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned CPU_MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                resetn,
`ifdef VIDEO_ARB_STATS_EN
    output logic [15:0]         stall_cnt,
`endif
    video_vram_arbiter_if.slave bus
);
    localparam logic [3:0] MaxWait = 4'(CPU_MAX_WAIT);

    typedef enum logic [1:0] {C_IDLE, C_READ, C_ACK} cpu_state_e;

    cpu_state_e        r_state;
    logic [3:0]        r_wait_cnt;
    logic              r_is_write;
    logic              r_cpu_ready;
    logic [31:0]       r_cpu_rdata;
    logic              r_vid_rvalid;

    logic              w_cpu_cand;
    logic              w_starve;
    logic              w_vid_sel;
    logic              w_vid_win;
    logic              w_cpu_win;
    logic [ADDR_W-1:0] w_mem_addr;

    // Grants are gated by resetn so the RAM sees no access while reset is held.
    always_comb begin
        w_cpu_cand = bus.cpu_valid && (r_state == C_IDLE);
        w_starve   = (r_wait_cnt == MaxWait);
        w_vid_sel  = bus.vid_req && !(w_cpu_cand && w_starve);
        w_vid_win  = resetn && w_vid_sel;
        w_cpu_win  = resetn && w_cpu_cand && !w_vid_sel;
        w_mem_addr = w_cpu_win ? bus.cpu_addr : bus.vid_addr;
    end

    assign bus.vid_gnt    = w_vid_win;
    assign bus.mem_en     = w_vid_win | w_cpu_win;
    assign bus.mem_we     = w_cpu_win ? bus.cpu_wstrb : 4'b0000;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_cpu_win ? bus.cpu_wdata : 32'h0;
    assign bus.vid_rdata  = bus.mem_rdata;
    assign bus.cpu_ready  = r_cpu_ready;
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.vid_rvalid = r_vid_rvalid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= C_IDLE;
            r_wait_cnt   <= 4'd0;
            r_is_write   <= 1'b0;
            r_cpu_ready  <= 1'b0;
            r_cpu_rdata  <= 32'h0;
            r_vid_rvalid <= 1'b0;
        end else begin
            r_vid_rvalid <= w_vid_win;
            r_cpu_ready  <= 1'b0;
            if (w_cpu_cand && w_vid_win) begin
                r_wait_cnt <= w_starve ? r_wait_cnt : r_wait_cnt + 4'd1;
            end else begin
                r_wait_cnt <= 4'd0;
            end
            case (r_state)
                C_IDLE: begin
                    if (w_cpu_win) begin
                        r_is_write <= |bus.cpu_wstrb;
                        r_state    <= C_READ;
                    end
                end
                C_READ: begin
                    r_cpu_rdata <= r_is_write ? 32'h0 : bus.mem_rdata;
                    r_cpu_ready <= 1'b1;
                    r_state     <= C_ACK;
                end
                C_ACK:   r_state <= C_IDLE;
                default: r_state <= C_IDLE;
            endcase
        end
    end

`ifdef VIDEO_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt <= 16'h0;
        end else if (w_cpu_cand && w_vid_win && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif
endmodule
